// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: per-pin direction/output/alternate drive, a two-flop
// synchronizer and glitch filter on every input, and edge interrupts folded into one line.
module gpio_port #(
    parameter int WIDTH     = 16,
    parameter int FILT_BITS = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [2:0]           i_memAddr,
    input  logic [15:0]          i_memDataIn,
    input  logic                 i_memWrEn,
    output logic [15:0]          o_memDataOut,
    input  logic [WIDTH-1:0]     i_altOut,
    output logic [WIDTH-1:0]     o_pinIn,
    output logic                 o_intGpio,
    inout  wire  [WIDTH-1:0]     io_gpioPins
);

    localparam logic [2:0] A_ALT  = 3'd0;
    localparam logic [2:0] A_IN   = 3'd1;
    localparam logic [2:0] A_DIR  = 3'd2;
    localparam logic [2:0] A_OUT  = 3'd3;
    localparam logic [2:0] A_RISE = 3'd4;
    localparam logic [2:0] A_FALL = 3'd5;
    localparam logic [2:0] A_PEND = 3'd6;
    localparam logic [2:0] A_FILT = 3'd7;

    logic [WIDTH-1:0]     alt_q, dir_q, out_q, rise_en_q, fall_en_q;
    logic [WIDTH-1:0]     pend_q, pend_d;
    logic [FILT_BITS-1:0] filt_q;
    logic [WIDTH-1:0]     sync1_q, sync_q;
    logic [WIDTH-1:0]     stb_q, stb_d, prv_q;
    logic [FILT_BITS-1:0] cnt_q [WIDTH];
    logic [FILT_BITS-1:0] cnt_d [WIDTH];
    logic                 int_q;
    logic [WIDTH-1:0]     wdata_w, clr_w, rise_w, fall_w, pin_val_w;
    logic [15:0]          rd_w;

    assign wdata_w = i_memDataIn[WIDTH-1:0];

    // Pin drive is purely combinational from register state and i_altOut.
    assign pin_val_w = (alt_q & i_altOut) | (~alt_q & out_q);
    for (genvar g = 0; g < WIDTH; g++) begin : g_pin
        assign io_gpioPins[g] = dir_q[g] ? pin_val_w[g] : 1'bz;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            alt_q     <= '0;
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            filt_q    <= '0;
        end else if (i_memWrEn) begin
            case (i_memAddr)
                A_ALT:   alt_q     <= wdata_w;
                A_DIR:   dir_q     <= wdata_w;
                A_OUT:   out_q     <= wdata_w;
                A_RISE:  rise_en_q <= wdata_w;
                A_FALL:  fall_en_q <= wdata_w;
                A_FILT:  filt_q    <= i_memDataIn[FILT_BITS-1:0];
                default: ;
            endcase
        end
    end

    // Level must persist FILT+1 cycles past the synchronizer before stb follows it.
    always_comb begin
        stb_d = stb_q;
        for (int n = 0; n < WIDTH; n++) begin
            cnt_d[n] = '0;
            if (sync_q[n] != stb_q[n]) begin
                if (cnt_q[n] == filt_q) begin
                    stb_d[n] = sync_q[n];
                end else begin
                    cnt_d[n] = cnt_q[n] + 1'b1;
                end
            end
        end
    end

    assign rise_w = stb_q & ~prv_q & rise_en_q;
    assign fall_w = ~stb_q & prv_q & fall_en_q;
    assign clr_w  = (i_memWrEn && i_memAddr == A_PEND) ? wdata_w : '0;
    // A set in the same cycle as a clear wins.
    assign pend_d = (pend_q & ~clr_w) | rise_w | fall_w;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync1_q <= '0;
            sync_q  <= '0;
            stb_q   <= '0;
            prv_q   <= '0;
            pend_q  <= '0;
            int_q   <= 1'b0;
            for (int n = 0; n < WIDTH; n++) cnt_q[n] <= '0;
        end else begin
            sync1_q <= io_gpioPins;
            sync_q  <= sync1_q;
            stb_q   <= stb_d;
            prv_q   <= stb_q;
            pend_q  <= pend_d;
            int_q   <= |pend_q;
            for (int n = 0; n < WIDTH; n++) cnt_q[n] <= cnt_d[n];
        end
    end

    always_comb begin
        rd_w = '0;
        case (i_memAddr)
            A_ALT:   rd_w[WIDTH-1:0]     = alt_q;
            A_IN:    rd_w[WIDTH-1:0]     = stb_q;
            A_DIR:   rd_w[WIDTH-1:0]     = dir_q;
            A_OUT:   rd_w[WIDTH-1:0]     = out_q;
            A_RISE:  rd_w[WIDTH-1:0]     = rise_en_q;
            A_FALL:  rd_w[WIDTH-1:0]     = fall_en_q;
            A_PEND:  rd_w[WIDTH-1:0]     = pend_q;
            default: rd_w[FILT_BITS-1:0] = filt_q;
        endcase
    end

    assign o_memDataOut = rd_w;
    assign o_pinIn      = stb_q;
    assign o_intGpio    = int_q;

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port: the driver pushes expected values into a queue,
// and a monitor pops and compares each one when the driver flags the sample point.
module tb_gpio_port;

  localparam int K_REG  = 0;
  localparam int K_PINS = 1;
  localparam int K_INT  = 2;
  localparam int K_PIN  = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic        we = 1'b0;
  logic [15:0] rdata;
  logic [15:0] alt_out = '0;
  logic [15:0] pin_in;
  logic        int_gpio;
  wire  [15:0] pins;
  logic [15:0] tb_en = '0;
  logic [15:0] tb_val = '0;

  logic [15:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];
  event        chk_ev;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          done = 1'b0;

  // The pad ring: bench-side drivers plus a pulldown so an undriven pin reads 0.
  for (genvar g = 0; g < 16; g++) begin : g_tb_pin
    assign pins[g] = tb_en[g] ? tb_val[g] : 1'bz;
    pulldown pd (pins[g]);
  end

  gpio_port #(.WIDTH(16), .FILT_BITS(4)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_memAddr    (addr),
    .i_memDataIn  (wdata),
    .i_memWrEn    (we),
    .o_memDataOut (rdata),
    .i_altOut     (alt_out),
    .o_pinIn      (pin_in),
    .o_intGpio    (int_gpio),
    .io_gpioPins  (pins)
  );

  always #10 clk = ~clk;

  // Monitor
  initial begin
    logic [15:0] e, act;
    int          k;
    string       nm;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        k  = kind_q.pop_front();
        nm = name_q.pop_front();
        case (k)
          K_REG:   act = rdata;
          K_PINS:  act = pins;
          K_INT:   act = {15'd0, int_gpio};
          default: act = pin_in;
        endcase
        n_chk++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", nm, act, e);
        end
      end
    end
  end

  // Watchdog
  initial begin
    repeat (20000) @(posedge clk);
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: stimulus did not complete");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  task automatic check_now(input logic [15:0] act, input logic [15:0] e, input string nm);
    n_chk++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic chk(input int kind, input logic [2:0] a, input logic [15:0] e, input string nm);
    addr = a;
    #1;
    exp_q.push_back(e);
    kind_q.push_back(kind);
    name_q.push_back(nm);
    -> chk_ev;
    #1;
  endtask

  task automatic wait_pos(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk(K_INT, 3'd0, 16'h0000, "int_in_rst");
    rstn = 1'b1;
    wait_pos(2);

    addr = 3'd0;
    #1;
    check_now({15'd0, int_gpio}, 16'h0000, "rst_state_int");
    check_now(pin_in, 16'h0000, "rst_state_pin_in");
    check_now(rdata, 16'h0000, "rst_state_alt");

    for (int a = 0; a < 8; a++) chk(K_REG, 3'(a), 16'h0000, "rst_reg");
    chk(K_PINS, 3'd0, 16'h0000, "rst_pins_z");
    chk(K_PIN,  3'd0, 16'h0000, "rst_pin_in");

    wr(3'd2, 16'h00FF);
    wr(3'd3, 16'h00A5);
    chk(K_PINS, 3'd0, 16'h00A5, "dir_pins");
    wait_pos(4);
    chk(K_REG, 3'd1, 16'h00A5, "dir_in_reg");
    chk(K_PIN, 3'd0, 16'h00A5, "dir_pin_in");
    wr(3'd3, 16'hFFA5);
    chk(K_PINS, 3'd0, 16'h00A5, "upper_z");
    chk(K_REG,  3'd3, 16'hFFA5, "out_rb");
    wr(3'd1, 16'hFFFF);
    wait_pos(4);
    chk(K_REG, 3'd1, 16'h00A5, "in_read_only");
    wr(3'd2, 16'h0000);
    wr(3'd3, 16'h0000);

    wr(3'd0, 16'h0C00);
    wr(3'd2, 16'h0C00);
    chk(K_PINS, 3'd0, 16'h0000, "alt_idle");
    alt_out = 16'h0800;
    chk(K_PINS, 3'd0, 16'h0800, "alt_pass_11");
    alt_out = 16'h0400;
    chk(K_PINS, 3'd0, 16'h0400, "alt_pass_10");
    alt_out = 16'h0000;
    wr(3'd3, 16'h0C00);
    chk(K_PINS, 3'd0, 16'h0000, "alt_over_out");
    wr(3'd2, 16'h0000);
    wr(3'd0, 16'h0000);
    wr(3'd3, 16'h0000);
    wait_pos(4);
    chk(K_REG, 3'd1, 16'h0000, "in_idle");

    wr(3'd7, 16'hFFF3);
    chk(K_REG, 3'd7, 16'h0003, "filt_mask");
    tb_en  = 16'h0013;
    tb_val = 16'h0000;
    wait_pos(4);
    tb_val[4] = 1'b1;
    repeat (3) @(negedge clk);
    tb_val[4] = 1'b0;
    wait_pos(8);
    chk(K_REG, 3'd1, 16'h0000, "glitch_reject");
    tb_val[4] = 1'b1;
    wait_pos(5);
    chk(K_REG, 3'd1, 16'h0000, "filt_edge5");
    wait_pos(1);
    chk(K_REG, 3'd1, 16'h0010, "filt_edge6");
    tb_val[4] = 1'b0;
    wait_pos(8);
    wr(3'd7, 16'h0000);

    wr(3'd4, 16'h0001);
    wr(3'd5, 16'h0002);
    tb_val[0] = 1'b1;
    wait_pos(3);
    chk(K_REG, 3'd1, 16'h0001, "in_latency");
    chk(K_REG, 3'd6, 16'h0000, "pend_pre");
    wait_pos(1);
    chk(K_REG, 3'd6, 16'h0001, "pend_latency");
    chk(K_INT, 3'd0, 16'h0000, "int_pre");
    wait_pos(1);
    chk(K_INT, 3'd0, 16'h0001, "int_latency");
    tb_val[1] = 1'b1;
    wait_pos(6);
    chk(K_REG, 3'd6, 16'h0001, "no_rise_pin1");
    tb_val[1] = 1'b0;
    wait_pos(6);
    chk(K_REG, 3'd6, 16'h0003, "fall_pin1");

    wr(3'd6, 16'h0001);
    chk(K_REG, 3'd6, 16'h0002, "w1c");
    chk(K_INT, 3'd0, 16'h0001, "int_stays");
    tb_val[1] = 1'b1;
    wait_pos(6);
    tb_val[1] = 1'b0;
    repeat (3) @(posedge clk);
    wr(3'd6, 16'h0002);
    chk(K_REG, 3'd6, 16'h0002, "set_wins");

    wr(3'd6, 16'h0003);
    chk(K_REG, 3'd6, 16'h0000, "clear_all");
    chk(K_INT, 3'd0, 16'h0001, "int_hold_1");
    wait_pos(1);
    chk(K_INT, 3'd0, 16'h0000, "int_drop");

    tb_val[0] = 1'b0;
    wait_pos(6);
    tb_val[0] = 1'b1;
    wait_pos(6);
    wr(3'd4, 16'h0000);
    chk(K_REG, 3'd6, 16'h0001, "rise_clr_keeps");

    wr(3'd7, 16'h000F);
    wr(3'd3, 16'h0100);
    wr(3'd2, 16'h0100);
    chk(K_PINS, 3'd0, 16'h0101, "pin8_driven");
    chk(K_INT,  3'd0, 16'h0001, "int_before_rst");
    tb_val[1] = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    chk(K_REG,  3'd1, 16'h0000, "rst_in");
    chk(K_REG,  3'd6, 16'h0000, "rst_pend");
    chk(K_REG,  3'd2, 16'h0000, "rst_dir");
    chk(K_REG,  3'd7, 16'h0000, "rst_filt");
    chk(K_INT,  3'd0, 16'h0000, "rst_int");
    chk(K_PIN,  3'd0, 16'h0000, "rst_pin_in2");
    chk(K_PINS, 3'd0, 16'h0003, "rst_pins");
    @(negedge clk);
    rstn = 1'b1;
    wait_pos(6);
    chk(K_REG, 3'd1, 16'h0003, "post_rst_in");
    chk(K_REG, 3'd6, 16'h0000, "no_evt_after_rst");
    wr(3'd4, 16'h0001);
    wait_pos(6);
    chk(K_REG, 3'd6, 16'h0000, "rise_en_while_high");
    chk(K_INT, 3'd0, 16'h0000, "int_quiet");

    done = 1'b1;
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
